// File: rtl/game_state_shadow_pkg.sv
// Shared constants and FSM encoding for the game-state shadow register bank.
package game_state_shadow_pkg;

    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;

    localparam int unsigned PIPE_X_BASE  = 0;
    localparam int unsigned PIPE_YC_BASE = 4;
    localparam int unsigned PIPE_YS_BASE = 8;
    localparam int unsigned BIRD_ADDR    = 12;
    localparam int unsigned SCORE_ADDR   = 13;
    localparam int unsigned HISCORE_ADDR = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } state_t;

endpackage

// File: rtl/game_state_shadow_frame_edge_detect.sv
// Registers the synchronised frame-boundary level and flags its rising edge.
module frame_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/game_state_shadow.sv
// Double-buffered game-state bank: CPU writes a staging set, display bank
// takes a copy only at a frame boundary after a commit.
module game_state_shadow #(
    parameter int unsigned NUM_REGS = game_state_shadow_pkg::NUM_REGS,
    parameter int unsigned DATA_W   = game_state_shadow_pkg::DATA_W,
    parameter int unsigned ADDR_W   = game_state_shadow_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       commit,
    input  logic                       frame_end,
    output logic [NUM_REGS*DATA_W-1:0] disp_regs,
    output logic                       game_underway,
    output logic                       swap_pulse,
    output logic [15:0]                frame_count,
    output logic [7:0]                 dropped_commits
);

    import game_state_shadow_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] staging_q [NUM_REGS];
    logic [DATA_W-1:0] display_q [NUM_REGS];
    logic [15:0]       frame_count_q;
    logic [7:0]        dropped_q;
    logic              frame_edge;
    logic              load_display;
    logic              drop;
    logic              wr_fire;

    frame_edge_detect u_frame_edge_detect (
        .clk   (clk),
        .reset (reset),
        .level (frame_end),
        .rise  (frame_edge)
    );

    // Addresses past the last register are accepted but discarded.
    assign wr_fire = wr_en & wr_ready & (wr_addr <= LAST_ADDR);

    always_comb begin
        state_d      = state_q;
        wr_ready     = 1'b0;
        swap_pulse   = 1'b0;
        load_display = 1'b0;
        drop         = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (commit) state_d = PENDING;
            end
            PENDING: begin
                drop = commit;
                if (frame_edge) state_d = SWAP;
            end
            SWAP: begin
                swap_pulse   = 1'b1;
                load_display = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            staging_q     <= '{default: '0};
            display_q     <= '{default: '0};
            frame_count_q <= '0;
            dropped_q     <= '0;
        end else begin
            state_q <= state_d;
            if (wr_fire) staging_q[wr_addr] <= wr_data;
            if (load_display) display_q <= staging_q;
            if (frame_edge) frame_count_q <= frame_count_q + 16'd1;
            if (drop && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;
        end
    end

    // High score alone does not mean a game is running, so it is left out.
    always_comb begin
        disp_regs     = '0;
        game_underway = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            disp_regs[i*DATA_W +: DATA_W] = display_q[i];
            if (i != HISCORE_ADDR) game_underway = game_underway | (|display_q[i]);
        end
    end

    assign frame_count     = frame_count_q;
    assign dropped_commits = dropped_q;

endmodule

// File: tb/tb_game_state_shadow.sv
// Scoreboard bench: stimulus queues expected display images, a monitor
// compares them whenever the DUT signals a swap.
module tb_game_state_shadow;

    localparam int unsigned IMG_W = 15 * 32;

    typedef struct {
        logic [IMG_W-1:0] img;
        logic             gu;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic              wr_ready;
    logic              commit = 1'b0;
    logic              frame_end = 1'b0;
    logic [IMG_W-1:0]  disp_regs;
    logic              game_underway;
    logic              swap_pulse;
    logic [15:0]       frame_count;
    logic [7:0]        dropped_commits;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;

    game_state_shadow #(.NUM_REGS(15), .DATA_W(32), .ADDR_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .commit          (commit),
        .frame_end       (frame_end),
        .disp_regs       (disp_regs),
        .game_underway   (game_underway),
        .swap_pulse      (swap_pulse),
        .frame_count     (frame_count),
        .dropped_commits (dropped_commits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] slot(input int unsigned idx, input logic [31:0] v);
        return IMG_W'(v) << (idx * 32);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (3) tick();
    endtask

    task automatic expect_swap(input logic [IMG_W-1:0] img, input logic gu);
        exp_t e;
        e.img = img;
        e.gu  = gu;
        exp_q.push_back(e);
    endtask

    // Display updates on the edge closing the swap_pulse cycle, so compare one negedge later.
    initial begin : monitor
        bit   cmp_next = 1'b0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (cmp_next) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_swap: got swap with display %0h, expected no swap", disp_regs);
                end else begin
                    e = exp_q.pop_front();
                    chk("swap_disp_regs", disp_regs, e.img);
                    chk("swap_game_underway", IMG_W'(game_underway), IMG_W'(e.gu));
                end
            end
            cmp_next = swap_pulse;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_disp_regs", disp_regs, '0);
        chk("reset_wr_ready", IMG_W'(wr_ready), IMG_W'(1));
        chk("reset_game_underway", IMG_W'(game_underway), IMG_W'(0));
        chk("reset_frame_count", IMG_W'(frame_count), IMG_W'(0));
        chk("reset_swap_pulse", IMG_W'(swap_pulse), IMG_W'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Basic swap
        write(4'd0, 32'd100);
        write(4'd12, 32'd200);
        do_commit();
        expect_swap(slot(0, 100) | slot(12, 200), 1'b1);
        frame_pulse();
        chk("basic_frame_count", IMG_W'(frame_count), IMG_W'(1));
        chk("basic_wr_ready", IMG_W'(wr_ready), IMG_W'(1));

        // No commit: frames pass, display keeps reset contents
        do_reset();
        write(4'd13, 32'd5);
        repeat (3) frame_pulse();
        chk("nocommit_disp_regs", disp_regs, '0);
        chk("nocommit_frame_count", IMG_W'(frame_count), IMG_W'(3));

        // Pending stall: write ignored, extra commits dropped
        do_commit();
        chk("pending_wr_ready", IMG_W'(wr_ready), IMG_W'(0));
        write(4'd1, 32'd7);
        do_commit();
        do_commit();
        chk("pending_dropped", IMG_W'(dropped_commits), IMG_W'(2));
        expect_swap(slot(13, 5), 1'b1);
        frame_pulse();
        chk("pending_dropped_after", IMG_W'(dropped_commits), IMG_W'(2));

        // Commit coincident with frame rise, level held high: one edge, no swap yet
        do_reset();
        write(4'd14, 32'd9);
        commit = 1'b1; frame_end = 1'b1;
        tick();
        commit = 1'b0;
        repeat (3) tick();
        frame_end = 1'b0;
        repeat (2) tick();
        chk("samecyc_still_pending", IMG_W'(wr_ready), IMG_W'(0));
        chk("samecyc_frame_count", IMG_W'(frame_count), IMG_W'(1));
        chk("samecyc_disp_regs", disp_regs, '0);
        // High score alone must not count as a game underway
        expect_swap(slot(14, 9), 1'b0);
        frame_end = 1'b1;
        tick();
        // Now in the swap cycle: commit and write must be ignored
        commit = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd55;
        tick();
        commit = 1'b0; wr_en = 1'b0; frame_end = 1'b0;
        repeat (3) tick();
        chk("swapcyc_dropped", IMG_W'(dropped_commits), IMG_W'(0));
        chk("swapcyc_wr_ready", IMG_W'(wr_ready), IMG_W'(1));

        // Address 15 is discarded; reg0 never got the swap-cycle write
        write(4'd15, 32'hDEAD);
        do_commit();
        expect_swap(slot(14, 9), 1'b0);
        frame_pulse();
        chk("addr15_frame_count", IMG_W'(frame_count), IMG_W'(3));

        // Reset in the middle of a pending swap
        write(4'd3, 32'd44);
        do_commit();
        do_reset();
        chk("rstpend_disp_regs", disp_regs, '0);
        chk("rstpend_wr_ready", IMG_W'(wr_ready), IMG_W'(1));
        chk("rstpend_frame_count", IMG_W'(frame_count), IMG_W'(0));
        frame_pulse();
        chk("rstpend_no_swap_disp", disp_regs, '0);

        // Dropped-commit saturation
        do_commit();
        commit = 1'b1;
        repeat (300) tick();
        commit = 1'b0;
        chk("dropped_saturate", IMG_W'(dropped_commits), IMG_W'(255));
        expect_swap('0, 1'b0);
        frame_pulse();

        // Frame counter wrap
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        #1;
        chk("wrap_preset", IMG_W'(frame_count), IMG_W'(16'hFFFF));
        tick();
        frame_pulse();
        chk("wrap_frame_count", IMG_W'(frame_count), IMG_W'(0));

        repeat (4) tick();
        chk("scoreboard_empty", IMG_W'(exp_q.size()), IMG_W'(0));
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_state_shadow.md
# game_state_shadow

Frame-synchronous double-buffered register bank between the processor's memory-mapped game-state writes and the VGA display controller. The processor writes pipe, bird and score values into a staging bank at any time and marks the set complete with a commit. The block copies the staged set into the display bank only at a frame boundary, so the display never renders a half-updated frame. Its outputs drive the display controller's pipe, bird and score inputs and its splash/game selection.

## Interface
Parameters:
- NUM_REGS, 15: number of game-state registers.
- DATA_W, 32: register width.
- ADDR_W, 4: write address width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  staging register index.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write and commit accepted this cycle.
- commit  in  1  staged set complete; request a swap at the next frame edge.
- frame_end  in  1  frame-boundary level (screenEnd after synchronisation into clk); rising edge used.
- disp_regs  out  NUM_REGS*DATA_W  display bank; register i occupies bits [i*DATA_W +: DATA_W].
- game_underway  out  1  OR of display registers 0..13 being non-zero.
- swap_pulse  out  1  high for one cycle when the display bank updates.
- frame_count  out  16  number of frame edges seen.
- dropped_commits  out  8  commits rejected while a swap was pending; saturates.

## Operation
Address map:
- 0–3: pipe1..4 x.
- 4–7: pipe1..4 gap centre.
- 8–11: pipe1..4 gap height.
- 12: bird top edge.
- 13: current score.
- 14: high score.
- 15: write ignored; no other effect.

FSM states:
- IDLE: wr_ready=1.
  - A write with wr_en=1 updates staging[wr_addr].
  - commit=1 moves the FSM to PENDING.
- PENDING: wr_ready=0.
  - Writes are ignored.
  - commit increments dropped_commits, saturating at 255.
  - A frame edge moves the FSM to SWAP.
- SWAP: one cycle.
  - Display bank loads the staging bank.
  - swap_pulse=1, wr_ready=0.
  - Next state is IDLE.

Frame edge and counter:
- frame_edge = frame_end & ~frame_end_q, where frame_end_q is a registered copy.
- frame_count increments on every frame edge in any state and wraps 0xFFFF→0.

Outputs and staging:
- game_underway is combinational from the display bank.
- The staging bank is not cleared by a swap; unwritten registers persist.

## Timing
- Reset (reset=0 at a clk edge):
  - staging, display, frame_count, dropped_commits, frame_end_q all 0.
  - FSM in IDLE; wr_ready=1; swap_pulse=0; game_underway=0.
- Write latency: staging updates at the clk edge where wr_en & wr_ready.
- Write and commit in the same IDLE cycle: the write lands and is included in the swap.
- Commit and frame edge in the same IDLE cycle: the FSM enters PENDING and that edge is not consumed. The swap happens at the next frame edge.
- Swap timing: the display bank and swap_pulse update at the clk edge after the frame edge is detected in PENDING. That is 2 clk after frame_end rises: one cycle for the edge register, one for SWAP.
- Commit during SWAP: ignored and not counted as dropped.
- Write during SWAP: ignored, since wr_ready=0.
- Reset asserted mid-PENDING or mid-SWAP: the pending swap is abandoned and all state returns to reset values.
- frame_end held high for multiple cycles: exactly one edge.

## Structure
- Shared package holds:
  - address constants (PIPE_X_BASE=0, PIPE_YC_BASE=4, PIPE_YS_BASE=8, BIRD_ADDR=12, SCORE_ADDR=13, HISCORE_ADDR=14);
  - FSM state encoding (IDLE, PENDING, SWAP);
  - NUM_REGS and DATA_W.
- One natural sub-module: frame_edge_detect, which holds the registered level and produces the one-cycle rising-edge pulse. The rest is a single module.

## Test plan
- Reset: hold reset=0 for 3 cycles → all disp_regs 0, wr_ready=1, game_underway=0, frame_count=0.
- Basic swap: write addr 0=100 and addr 12=200, commit, then raise frame_end → 2 clk later disp reg0=100, reg12=200, swap_pulse for one cycle, game_underway=1.
- No commit: write addr 13=5 with no commit, toggle frame_end 3 times → display unchanged (0), frame_count=3.
- Pending stall: commit, then write addr 1=7 and commit twice before the frame edge → write ignored, dropped_commits=2; after the swap reg1 holds its prior staged value.
- Same-cycle events: commit coincident with a frame_end rise → no swap on that edge; swap on the following edge.
- Edge cases:
  - Write to addr 15 → no change.
  - Reset during PENDING → FSM returns to IDLE and the display bank clears.
  - frame_count at 0xFFFF plus one edge → 0.
